// File: rtl/wav_ahb2apb.sv
// wav_ahb2apb: AHB-Lite slave to APB3 master bridge, one 32-bit transfer at a time.
// Define WAV_AHB2APB_PSLVERR_EN to turn APB slave errors into AHB ERROR responses.
module wav_ahb2apb #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
) (
   input  logic              i_hclk,
   input  logic              i_hrst_n,
   input  logic              i_hsel,
   input  logic [AWIDTH-1:0] i_haddr,
   input  logic              i_hwrite,
   input  logic [1:0]        i_htrans,
   input  logic [2:0]        i_hsize,
   input  logic [2:0]        i_hburst,
   input  logic [DWIDTH-1:0] i_hwdata,
   input  logic              i_hready,
   output logic              o_hready,
   output logic [1:0]        o_hresp,
   output logic [DWIDTH-1:0] o_hrdata,
   output logic [AWIDTH-1:0] o_paddr,
   output logic              o_psel,
   output logic              o_penable,
   output logic              o_pwrite,
   output logic [DWIDTH-1:0] o_pwdata,
   input  logic [DWIDTH-1:0] i_prdata,
   input  logic              i_pready,
   input  logic              i_pslverr
);
   localparam logic [2:0] AHB_SIZE_WORD  = 3'b010;
   localparam logic [1:0] AHB_RESP_OK    = 2'b00;
   localparam logic [1:0] AHB_RESP_ERROR = 2'b01;
   typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;
   state_t state_q, state_d;
   logic accept, legal, err, can_accept;
   logic unused_ok;
   assign accept     = i_hsel & i_hready & i_htrans[1];
   assign legal      = (i_hsize == AHB_SIZE_WORD) && (i_haddr[1:0] == 2'b00);
   assign can_accept = (state_q == IDLE) || (state_q == ERR2);
`ifdef WAV_AHB2APB_PSLVERR_EN
   assign err       = i_pslverr;
   assign unused_ok = ^i_hburst;
`else
   assign err       = 1'b0;
   assign unused_ok = ^{i_hburst, i_pslverr};
`endif
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, ERR2: state_d = !accept ? IDLE : !legal ? ERR1 : i_hwrite ? WDATA : SETUP;
         WDATA:      state_d = SETUP;
         SETUP:      state_d = ACCESS;
         ACCESS:     state_d = !i_pready ? ACCESS : err ? ERR1 : IDLE;
         ERR1:       state_d = ERR2;
         default:    state_d = IDLE;
      endcase
   end
   // Outputs are registered decodes of the next state so they align with state_q.
   always_ff @(posedge i_hclk or negedge i_hrst_n) begin
      if (!i_hrst_n) begin
         state_q   <= IDLE;
         o_hready  <= 1'b1;
         o_hresp   <= AHB_RESP_OK;
         o_hrdata  <= '0;
         o_psel    <= 1'b0;
         o_penable <= 1'b0;
         o_pwrite  <= 1'b0;
         o_paddr   <= '0;
         o_pwdata  <= '0;
      end else begin
         state_q   <= state_d;
         o_hready  <= (state_d == IDLE) || (state_d == ERR2);
         o_hresp   <= ((state_d == ERR1) || (state_d == ERR2)) ? AHB_RESP_ERROR : AHB_RESP_OK;
         o_psel    <= (state_d == SETUP) || (state_d == ACCESS);
         o_penable <= (state_d == ACCESS);
         if (accept && can_accept) begin
            o_paddr  <= i_haddr;
            o_pwrite <= i_hwrite;
         end
         if (state_q == WDATA) o_pwdata <= i_hwdata;
         if ((state_q == ACCESS) && i_pready && !err && !o_pwrite) o_hrdata <= i_prdata;
      end
   end
endmodule
